// File: rtl/delay_tap_cal_if.sv
`default_nettype none
// ============================================================================
// Module      : delay_tap_cal_if
// Description : Host/sample-path bundle between delay_tap_cal and its user.
// Revision    : 1.0 - initial release
// ============================================================================
interface delay_tap_cal_if;
  logic               start;
  logic               ref_trig;
  logic signed [12:0] din;
  logic signed [12:0] threshold;
  logic        [4:0]  tap;
  logic               sr_bypass;
  logic               busy;
  logic               done;
  logic               err;
  logic               sat;
  logic        [5:0]  meas_avg;

  modport master (
    output start, ref_trig, din, threshold,
    input  tap, sr_bypass, busy, done, err, sat, meas_avg
  );

  modport slave (
    input  start, ref_trig, din, threshold,
    output tap, sr_bypass, busy, done, err, sat, meas_avg
  );
endinterface
`default_nettype wire

// File: rtl/delay_tap_cal.sv
`default_nettype none
// ============================================================================
// Module      : delay_tap_cal
// Description : Averages trigger-to-crossing latency and derives delay-line
//               tap / bypass settings that align the stream to TARGET_LAT.
// Revision    : 1.0 - initial release
// ============================================================================
module delay_tap_cal #(
  parameter int TARGET_LAT = 24,
  parameter int TIMEOUT    = 63,
  parameter int LOG2_MEAS  = 2
) (
  input  logic            clk,
  input  logic            rst,
  delay_tap_cal_if.slave  bus
);

  localparam int ACC_W = 6 + LOG2_MEAS;
  localparam int IDX_W = LOG2_MEAS + 1;

  localparam logic [5:0]       c_wait_last = 6'(TIMEOUT - 1);
  localparam logic [5:0]       c_lat_last  = 6'(TIMEOUT);
  localparam logic [IDX_W-1:0] c_meas_n    = IDX_W'(1 << LOG2_MEAS);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARM   = 3'd1,
    S_COUNT = 3'd2,
    S_ACCUM = 3'd3,
    S_CALC  = 3'd4,
    S_DONE  = 3'd5,
    S_ERR   = 3'd6
  } state_t;

  state_t             state_q;
  logic signed [12:0] thr_q;
  logic [ACC_W-1:0]   acc_q;
  logic [IDX_W-1:0]   idx_q;
  logic [5:0]         wait_q;
  logic [5:0]         lat_q;
  logic [5:0]         cap_q;
  logic [4:0]         tap_q;
  logic               byp_q;
  logic               busy_q;
  logic               done_q;
  logic               err_q;
  logic               sat_q;
  logic [5:0]         avg_q;

  logic               cross_d;
  logic [IDX_W-1:0]   idx_d;
  logic [5:0]         avg_d;
  logic signed [7:0]  diff_d;
  logic [4:0]         tap_d;
  logic               byp_d;
  logic               sat_d;

  always_comb begin
    cross_d = (bus.din >= thr_q);
    idx_d   = idx_q + IDX_W'(1);
    avg_d   = 6'(acc_q >> LOG2_MEAS);
    diff_d  = 8'(TARGET_LAT) - {2'b00, avg_d};
    tap_d   = 5'd0;
    byp_d   = 1'b1;
    sat_d   = 1'b0;
    // Zero residual delay is exact alignment, not a clamp.
    if (diff_d <= 8'sd0) begin
      byp_d = 1'b1;
      tap_d = 5'd0;
      sat_d = (diff_d != 8'sd0);
    end else if (diff_d > 8'sd31) begin
      byp_d = 1'b0;
      tap_d = 5'd31;
      sat_d = 1'b1;
    end else begin
      byp_d = 1'b0;
      tap_d = diff_d[4:0];
      sat_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      thr_q   <= '0;
      acc_q   <= '0;
      idx_q   <= '0;
      wait_q  <= '0;
      lat_q   <= '0;
      cap_q   <= '0;
      tap_q   <= 5'd0;
      byp_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      sat_q   <= 1'b0;
      avg_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            thr_q   <= bus.threshold;
            acc_q   <= '0;
            idx_q   <= '0;
            wait_q  <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= S_ARM;
          end
        end
        S_ARM: begin
          if (bus.ref_trig) begin
            if (cross_d) begin
              cap_q   <= 6'd0;
              state_q <= S_ACCUM;
            end else begin
              // lat_q holds the latency of the sample being examined.
              lat_q   <= 6'd1;
              state_q <= S_COUNT;
            end
          end else if (wait_q == c_wait_last) begin
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_ERR;
          end else begin
            wait_q <= wait_q + 6'd1;
          end
        end
        S_COUNT: begin
          if (cross_d) begin
            cap_q   <= lat_q;
            state_q <= S_ACCUM;
          end else if (lat_q == c_lat_last) begin
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_ERR;
          end else begin
            lat_q <= lat_q + 6'd1;
          end
        end
        S_ACCUM: begin
          acc_q  <= acc_q + ACC_W'(cap_q);
          idx_q  <= idx_d;
          wait_q <= '0;
          if (idx_d == c_meas_n) begin
            state_q <= S_CALC;
          end else begin
            state_q <= S_ARM;
          end
        end
        S_CALC: begin
          // Results land on the same edge that enters DONE.
          tap_q   <= tap_d;
          byp_q   <= byp_d;
          sat_q   <= sat_d;
          avg_q   <= avg_d;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_DONE;
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        S_ERR: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.tap       = tap_q;
  assign bus.sr_bypass = byp_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.sat       = sat_q;
  assign bus.meas_avg  = avg_q;

endmodule
`default_nettype wire

// File: tb/tb_delay_tap_cal.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_delay_tap_cal
// Description : Scoreboard bench driving two calibrators (TARGET_LAT 24 / 40).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_delay_tap_cal;

  localparam int TGT_A = 24;
  localparam int TGT_B = 40;

  typedef struct {
    bit is_err;
    int cyc;
    int tap;
    int byp;
    int sat;
    int avg;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic ref_trig = 1'b0;
  logic signed [12:0] din = '0;
  logic signed [12:0] thr = '0;
  int cyc = 0;

  int checks = 0;
  int failures = 0;

  exp_t qa[$];
  exp_t qb[$];
  int last_tap[2] = '{0, 0};
  int last_byp[2] = '{1, 1};
  int last_sat[2] = '{0, 0};
  int last_avg[2] = '{0, 0};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  delay_tap_cal_if ifa ();
  delay_tap_cal_if ifb ();

  assign ifa.start = start;
  assign ifa.ref_trig = ref_trig;
  assign ifa.din = din;
  assign ifa.threshold = thr;
  assign ifb.start = start;
  assign ifb.ref_trig = ref_trig;
  assign ifb.din = din;
  assign ifb.threshold = thr;

  delay_tap_cal #(.TARGET_LAT(TGT_A), .TIMEOUT(63), .LOG2_MEAS(2)) u_dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa)
  );

  delay_tap_cal #(.TARGET_LAT(TGT_B), .TIMEOUT(63), .LOG2_MEAS(2)) u_dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: mean of the four latencies, then clamp the residual delay.
  function automatic exp_t model(input int target, input int lats[4], input int done_cyc);
    exp_t e;
    int sum = 0;
    int avg;
    int d;
    foreach (lats[i]) sum += lats[i];
    avg = sum / 4;
    d = target - avg;
    e.is_err = 1'b0;
    e.cyc = done_cyc;
    e.avg = avg;
    if (d <= 0) begin
      e.byp = 1; e.tap = 0; e.sat = (d < 0) ? 1 : 0;
    end else if (d > 31) begin
      e.byp = 0; e.tap = 31; e.sat = 1;
    end else begin
      e.byp = 0; e.tap = d; e.sat = 0;
    end
    return e;
  endfunction

  function automatic exp_t held(input int k, input int err_cyc);
    exp_t e;
    e.is_err = 1'b1;
    e.cyc = err_cyc;
    e.tap = last_tap[k];
    e.byp = last_byp[k];
    e.sat = last_sat[k];
    e.avg = last_avg[k];
    return e;
  endfunction

  task automatic remember(input int k, input exp_t e);
    last_tap[k] = e.tap;
    last_byp[k] = e.byp;
    last_sat[k] = e.sat;
    last_avg[k] = e.avg;
  endtask

  function automatic logic signed [12:0] below(input logic signed [12:0] t);
    return 13'(int'(t) - int'($urandom_range(1, 1500)));
  endfunction

  function automatic logic signed [12:0] above(input logic signed [12:0] t);
    return 13'(int'(t) + int'($urandom_range(0, 1500)));
  endfunction

  function automatic logic signed [12:0] rnd_any();
    return 13'($urandom_range(0, 8191));
  endfunction

  task automatic check_evt(input string who, input exp_t e, input logic got_err, input logic dn,
                           input logic bsy, input logic [4:0] tp, input logic byp,
                           input logic st, input logic [5:0] av);
    chk({who, "_event_is_err"}, {31'd0, got_err}, e.is_err);
    chk({who, "_event_cycle"}, cyc, e.cyc);
    chk({who, "_tap"}, {27'd0, tp}, e.tap);
    chk({who, "_sr_bypass"}, {31'd0, byp}, e.byp);
    chk({who, "_sat"}, {31'd0, st}, e.sat);
    chk({who, "_meas_avg"}, {26'd0, av}, e.avg);
    chk({who, "_busy_at_end"}, {31'd0, bsy}, 0);
    if (got_err) chk({who, "_done_on_err"}, {31'd0, dn}, 0);
  endtask

  task automatic check_reset_one(input string tag, input logic [4:0] tp, input logic byp,
                                 input logic bsy, input logic dn, input logic er,
                                 input logic st, input logic [5:0] av);
    chk({tag, "_tap"}, {27'd0, tp}, 0);
    chk({tag, "_sr_bypass"}, {31'd0, byp}, 1);
    chk({tag, "_busy"}, {31'd0, bsy}, 0);
    chk({tag, "_done"}, {31'd0, dn}, 0);
    chk({tag, "_err"}, {31'd0, er}, 0);
    chk({tag, "_sat"}, {31'd0, st}, 0);
    chk({tag, "_meas_avg"}, {26'd0, av}, 0);
  endtask

  task automatic check_reset(input string tag);
    check_reset_one({tag, "_A"}, ifa.tap, ifa.sr_bypass, ifa.busy, ifa.done, ifa.err, ifa.sat, ifa.meas_avg);
    check_reset_one({tag, "_B"}, ifb.tap, ifb.sr_bypass, ifb.busy, ifb.done, ifb.err, ifb.sat, ifb.meas_avg);
  endtask

  // Monitors: pop one expectation per done pulse or rising err.
  initial begin : mon_a
    exp_t e;
    logic err_p = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && (ifa.done || (ifa.err && !err_p))) begin
        if (qa.size() == 0) begin
          checks++; failures++;
          $display("FAIL A_unexpected_event: got done=%0d err=%0d expected no event", ifa.done, ifa.err);
        end else begin
          e = qa.pop_front();
          check_evt("A", e, ifa.err && !err_p, ifa.done, ifa.busy, ifa.tap, ifa.sr_bypass, ifa.sat, ifa.meas_avg);
        end
      end
      err_p = ifa.err;
    end
  end

  initial begin : mon_b
    exp_t e;
    logic err_p = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && (ifb.done || (ifb.err && !err_p))) begin
        if (qb.size() == 0) begin
          checks++; failures++;
          $display("FAIL B_unexpected_event: got done=%0d err=%0d expected no event", ifb.done, ifb.err);
        end else begin
          e = qb.pop_front();
          check_evt("B", e, ifb.err && !err_p, ifb.done, ifb.busy, ifb.tap, ifb.sr_bypass, ifb.sat, ifb.meas_avg);
        end
      end
      err_p = ifb.err;
    end
  end

  task automatic do_start(input logic signed [12:0] t, output int s);
    @(negedge clk);
    start = 1'b1; thr = t; din = below(t); s = cyc;
    @(negedge clk);
    start = 1'b0;
    thr = rnd_any();   // threshold must have been latched at start
    chk("A_busy_after_start", {31'd0, ifa.busy}, 1);
    chk("A_err_cleared_by_start", {31'd0, ifa.err}, 0);
    chk("B_busy_after_start", {31'd0, ifb.busy}, 1);
    chk("B_err_cleared_by_start", {31'd0, ifb.err}, 0);
  endtask

  // Entered and left at a negedge where the DUT sits in ARM (or CALC after the last one).
  task automatic measure(input int lat, input logic signed [12:0] t, input bit noise, output int xcyc);
    int g = $urandom_range(0, 3);
    repeat (g) begin
      din = rnd_any();
      start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
    ref_trig = 1'b1;
    din = (lat == 0) ? above(t) : below(t);
    xcyc = cyc;
    @(negedge clk);
    ref_trig = 1'b0;
    for (int k = 1; k <= lat; k++) begin
      din = (k == lat) ? above(t) : below(t);
      ref_trig = noise ? ($urandom_range(0, 3) == 0) : 1'b0;
      if (k == lat) xcyc = cyc;
      @(negedge clk);
    end
    ref_trig = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    din = rnd_any();
    @(negedge clk);
    ref_trig = 1'b0;
  endtask

  task automatic run(input int la[4], input logic signed [12:0] t, input bit noise, input bit sid);
    int s;
    int xc = 0;
    exp_t e;
    do_start(t, s);
    for (int i = 0; i < 4; i++) measure(la[i], t, noise, xc);
    e = model(TGT_A, la, xc + 3); qa.push_back(e); remember(0, e);
    e = model(TGT_B, la, xc + 3); qb.push_back(e); remember(1, e);
    @(negedge clk);
    if (sid) start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (sid) begin
      chk("A_start_in_done_ignored", {31'd0, ifa.busy}, 0);
      chk("B_start_in_done_ignored", {31'd0, ifb.busy}, 0);
    end
  endtask

  task automatic run_timeout(input logic signed [12:0] t);
    int s;
    do_start(t, s);
    qa.push_back(held(0, s + 64));
    qb.push_back(held(1, s + 64));
    repeat (70) begin
      din = rnd_any();
      @(negedge clk);
    end
  endtask

  task automatic run_reset_mid_count(input logic signed [12:0] t);
    int s;
    do_start(t, s);
    ref_trig = 1'b1; din = below(t);
    @(negedge clk);
    ref_trig = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset("mid_count_reset");
    rst = 1'b0;
    for (int k = 0; k < 2; k++) remember(k, '{1'b0, 0, 0, 1, 0, 0});
    repeat (5) @(negedge clk);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int la[4];
    logic signed [12:0] t;
    rst = 1'b1; start = 1'b1;
    repeat (3) @(negedge clk);
    check_reset("por");
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("A_idle_after_reset", {31'd0, ifa.busy}, 0);
    chk("B_idle_after_reset", {31'd0, ifb.busy}, 0);

    run('{5, 5, 5, 5},     13'sd100, 1'b0, 1'b0);
    run('{3, 4, 4, 6},     13'sd100, 1'b0, 1'b1);
    run('{0, 0, 0, 0},     -13'sd50, 1'b0, 1'b0);
    run('{30, 30, 30, 30}, 13'sd7,   1'b0, 1'b0);
    run('{24, 24, 24, 24}, 13'sd0,   1'b0, 1'b0);
    run('{9, 9, 9, 9},     13'sd300, 1'b0, 1'b0);
    run('{8, 8, 8, 8},     13'sd300, 1'b0, 1'b0);
    run('{63, 63, 63, 62}, 13'sd10,  1'b0, 1'b0);
    run('{2, 2, 2, 2},     13'sd100, 1'b0, 1'b0);
    run_timeout(13'sd100);
    run('{1, 2, 3, 4},     13'sd100, 1'b1, 1'b0);
    run_reset_mid_count(13'sd100);

    for (int r = 0; r < 14; r++) begin
      for (int i = 0; i < 4; i++)
        la[i] = ($urandom_range(0, 9) == 0) ? 63 : int'($urandom_range(0, 40));
      t = 13'(int'($urandom_range(0, 4000)) - 2000);
      run(la, t, 1'b1, 1'($urandom_range(0, 1)));
    end

    repeat (10) @(negedge clk);
    chk("A_scoreboard_drained", qa.size(), 0);
    chk("B_scoreboard_drained", qb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/delay_tap_cal.md
Name: delay_tap_cal

Overview:
- Closed-loop calibration controller that produces the `tap` and `sr_bypass` settings consumed by the team's variable-tap 13-bit sample delay line.
- Measures the latency from a reference trigger strobe to the first threshold crossing on a 13-bit signed sample stream, averaged over 2^LOG2_MEAS triggers.
- Computes the delay needed to align that stream to TARGET_LAT cycles.
- Sits between the channel ADC sample path and the delay-line instance; the host starts it via a strobe and reads status.

Parameters:
- TARGET_LAT, 24: total desired latency (cycles) from ref_trig to aligned sample.
- TIMEOUT, 63: max cycles waited for a trigger or for a crossing, per measurement.
- LOG2_MEAS, 2: log2 of the number of measurements averaged (2^2 = 4).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle strobe; begins a calibration run
- ref_trig  in  1  one-cycle reference trigger strobe
- din  in  13  signed sample stream being aligned
- threshold  in  13  signed crossing threshold; sampled at start
- tap  out  5  delay-line tap setting
- sr_bypass  out  1  delay-line bypass select
- busy  out  1  high from the cycle after start until DONE/ERR
- done  out  1  one-cycle pulse when new tap/sr_bypass are valid
- err  out  1  level; timeout occurred in the last run; cleared by the next accepted start
- sat  out  1  level; the last result was clamped (low or high); updated with done
- meas_avg  out  6  last averaged measured latency (debug)

Behaviour:
- Reset (synchronous, rst=1 at posedge):
  - state=IDLE; tap=0; sr_bypass=1; busy=0; done=0; err=0; sat=0; meas_avg=0.
  - Accumulator and counters cleared.
  - rst mid-run aborts with no done pulse.
- All outputs are registered.
- IDLE:
  - start=1 → latch threshold into thr_q, clear acc and meas_idx, clear err, go to ARM, busy=1 next cycle.
  - start is ignored while busy.
- ARM: wait for ref_trig.
  - The wait counter starts at 0 on ARM entry and increments each cycle.
  - Reaching TIMEOUT without ref_trig → ERR.
  - ref_trig=1 → lat_cnt=0 and go to COUNT.
  - The din sample in the same cycle as ref_trig is evaluated as latency 0: if din >= thr_q (signed), capture 0 immediately and go to ACCUM.
- COUNT: lat_cnt increments by 1 per cycle.
  - First cycle with din >= thr_q (signed compare) → capture lat_cnt, go to ACCUM.
  - lat_cnt reaching TIMEOUT without a crossing → ERR.
  - ref_trig during COUNT is ignored.
- ACCUM: acc += captured latency.
  - acc width is 6+LOG2_MEAS bits; no overflow is possible.
  - meas_idx increments.
  - If meas_idx reaches 2^LOG2_MEAS → CALC; else → ARM, with the wait counter reset.
- CALC (1 cycle):
  - avg = acc >> LOG2_MEAS (truncating).
  - d = TARGET_LAT − avg, computed signed in 8 bits.
- DONE (1 cycle): outputs update, done=1, busy=0, return to IDLE.
  - d <= 0 → sr_bypass=1, tap=0, sat=1 (d=0 is not flagged: sat=0).
  - 1 <= d <= 31 → sr_bypass=0, tap=d, sat=0.
  - d > 31 → sr_bypass=0, tap=31, sat=1.
  - meas_avg=avg.
- ERR (1 cycle):
  - err=1, busy=0, return to IDLE.
  - tap, sr_bypass, sat and meas_avg hold their previous values; done stays 0.
- start in the same cycle as DONE/ERR is ignored; start is accepted in IDLE only.
- Latency: done asserts exactly 2 cycles after the final capture cycle (ACCUM→CALC→DONE).
- tap and sr_bypass never change except in the DONE cycle or on reset.

Test Plan:
- Reset → tap=0, sr_bypass=1, busy=0, done=0, err=0; start with rst=1 is ignored.
- thr=100, 4 triggers each with din rising to 200 five cycles after ref_trig → avg=5, tap=19, sr_bypass=0, sat=0, done pulse 2 cycles after the 4th crossing.
- Crossings at latencies 3,4,4,6 → acc=17, avg=4 (truncated), tap=20.
- din >= thr on the ref_trig cycle for all 4 → avg=0, tap=24; separately, latency 30 for all 4 → d=−6, sr_bypass=1, tap=0, sat=1.
- TARGET_LAT=40 override, latency 2 → d=38 → tap=31, sat=1.
- No ref_trig for 63 cycles → err=1, no done, prior tap kept; next start clears err. In a second run, rst mid-COUNT → all outputs return to reset values.
